// File: rtl/counter_mod_prog.sv
// counter_mod_prog: programmable-modulus up/down counter with load, wrap/saturate,
// terminal-count pulse, sticky overflow and snapshot capture.
module counter_mod_prog #(
    parameter int CNT_WIDTH = 16,
    parameter logic [CNT_WIDTH-1:0] RST_VAL = '0
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 cnt_en,
    input  logic                 cnt_dir,
    input  logic                 sat_mode,
    input  logic [CNT_WIDTH-1:0] mod_val,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 capture,
    input  logic                 ovf_clr,
    output logic [CNT_WIDTH-1:0] cnt_out,
    output logic                 tc_pulse,
    output logic                 ovf_sticky,
    output logic [CNT_WIDTH-1:0] cap_out,
    output logic                 cap_valid
);
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_cap;
    logic                 r_tc;
    logic                 r_ovf;
    logic                 r_capv;
    logic                 w_up_bnd;
    logic                 w_dn_over;
    logic                 w_dn_bnd;
    logic                 w_bnd;
    logic [CNT_WIDTH-1:0] w_up_nxt;
    logic [CNT_WIDTH-1:0] w_dn_nxt;
    logic [CNT_WIDTH-1:0] w_load_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;

    // A count above mod_val only exists after mod_val is lowered; down-steps clamp it without a boundary event.
    always_comb begin
        w_up_bnd   = r_cnt >= mod_val;
        w_dn_over  = r_cnt > mod_val;
        w_dn_bnd   = !w_dn_over && r_cnt == '0;
        w_bnd      = cnt_en && !load && (cnt_dir ? w_up_bnd : w_dn_bnd);
        w_up_nxt   = w_up_bnd ? (sat_mode ? mod_val : '0) : r_cnt + 1'b1;
        w_dn_nxt   = w_dn_over ? mod_val : w_dn_bnd ? (sat_mode ? '0 : mod_val) : r_cnt - 1'b1;
        w_load_nxt = load_val > mod_val ? mod_val : load_val;
        w_cnt_nxt  = load ? w_load_nxt : cnt_en ? (cnt_dir ? w_up_nxt : w_dn_nxt) : r_cnt;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_cnt  <= RST_VAL;
            r_tc   <= 1'b0;
            r_ovf  <= 1'b0;
            r_cap  <= '0;
            r_capv <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_tc   <= w_bnd;
            r_ovf  <= w_bnd || (r_ovf && !ovf_clr);
            r_cap  <= capture ? r_cnt : r_cap;
            r_capv <= capture;
        end
    end

    assign cnt_out    = r_cnt;
    assign tc_pulse   = r_tc;
    assign ovf_sticky = r_ovf;
    assign cap_out    = r_cap;
    assign cap_valid  = r_capv;
endmodule

// File: tb/tb_counter_mod_prog.sv
// tb_counter_mod_prog: directed vectors with hand-computed expectations, queued
// by the stimulus and checked by an independent monitor after each edge.
module tb_counter_mod_prog;
    typedef struct {
        logic [7:0] cnt;
        logic       tc;
        logic       ovf;
        logic [7:0] cap;
        logic       capv;
    } exp_t;

    logic       clk_in = 1'b0;
    logic       rst, cnt_en, cnt_dir, sat_mode, load, capture, ovf_clr;
    logic [7:0] mod_val, load_val;
    logic [7:0] cnt_out, cap_out;
    logic       tc_pulse, ovf_sticky, cap_valid;
    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;

    counter_mod_prog #(.CNT_WIDTH(8), .RST_VAL(8'd0)) dut (
        .clk_in(clk_in), .rst(rst), .cnt_en(cnt_en), .cnt_dir(cnt_dir),
        .sat_mode(sat_mode), .mod_val(mod_val), .load(load), .load_val(load_val),
        .capture(capture), .ovf_clr(ovf_clr), .cnt_out(cnt_out), .tc_pulse(tc_pulse),
        .ovf_sticky(ovf_sticky), .cap_out(cap_out), .cap_valid(cap_valid)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", n, a, e, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("cnt_out", cnt_out, e.cnt);
                chk("tc_pulse", {7'd0, tc_pulse}, {7'd0, e.tc});
                chk("ovf_sticky", {7'd0, ovf_sticky}, {7'd0, e.ovf});
                chk("cap_out", cap_out, e.cap);
                chk("cap_valid", {7'd0, cap_valid}, {7'd0, e.capv});
            end
        end
    end

    // Inputs for one edge, then the outputs expected after that edge.
    task automatic cyc(input logic r, input logic en, input logic dir, input logic sat,
                       input logic [7:0] m, input logic ld, input logic [7:0] lv,
                       input logic cp, input logic clr,
                       input logic [7:0] ec, input logic et, input logic eo,
                       input logic [7:0] ecap, input logic ecv);
        exp_t e;
        rst = r; cnt_en = en; cnt_dir = dir; sat_mode = sat; mod_val = m;
        load = ld; load_val = lv; capture = cp; ovf_clr = clr;
        e.cnt = ec; e.tc = et; e.ovf = eo; e.cap = ecap; e.capv = ecv;
        q.push_back(e);
        @(posedge clk_in);
        #2;
    endtask

    initial begin
        int budget;
        //  rst en dir sat mod  ld ldv  cp clr | cnt  tc ovf cap capv
        cyc(1, 0, 1, 0,   4, 0,   0, 0, 0,    0, 0, 0, 0, 0);
        // wrap up, mod 4
        cyc(0, 1, 1, 0,   4, 0,   0, 0, 0,    1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0,   4, 0,   0, 0, 0,    2, 0, 0, 0, 0);
        cyc(0, 1, 1, 0,   4, 0,   0, 0, 0,    3, 0, 0, 0, 0);
        cyc(0, 1, 1, 0,   4, 0,   0, 0, 0,    4, 0, 0, 0, 0);
        cyc(0, 1, 1, 0,   4, 0,   0, 0, 0,    0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0,   4, 0,   0, 0, 0,    1, 0, 1, 0, 0);
        cyc(0, 1, 1, 0,   4, 0,   0, 0, 0,    2, 0, 1, 0, 0);
        // saturating down from 2
        cyc(0, 0, 0, 1,   4, 1,   2, 0, 0,    2, 0, 1, 0, 0);
        cyc(0, 1, 0, 1,   4, 0,   0, 0, 0,    1, 0, 1, 0, 0);
        cyc(0, 1, 0, 1,   4, 0,   0, 0, 0,    0, 0, 1, 0, 0);
        cyc(0, 1, 0, 1,   4, 0,   0, 0, 0,    0, 1, 1, 0, 0);
        cyc(0, 1, 0, 1,   4, 0,   0, 0, 0,    0, 1, 1, 0, 0);
        cyc(0, 1, 0, 1,   4, 0,   0, 0, 0,    0, 1, 1, 0, 0);
        // ovf_clr loses to a boundary, wins otherwise
        cyc(0, 1, 0, 1,   4, 0,   0, 0, 1,    0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1,   4, 0,   0, 0, 1,    0, 0, 0, 0, 0);
        // load clamps to mod_val and suppresses the step
        cyc(0, 1, 1, 0, 100, 1, 200, 0, 0,  100, 0, 0, 0, 0);
        // capture with simultaneous load
        cyc(0, 0, 1, 0, 100, 1,   7, 0, 0,    7, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 100, 1,   3, 1, 0,    3, 0, 0, 7, 1);
        cyc(0, 0, 1, 0, 100, 0,   0, 0, 0,    3, 0, 0, 7, 0);
        // mod_val lowered below the count
        cyc(0, 0, 1, 0, 100, 1,  50, 0, 0,   50, 0, 0, 7, 0);
        cyc(0, 1, 1, 0,  20, 0,   0, 0, 0,    0, 1, 1, 7, 0);
        cyc(0, 0, 1, 0, 100, 1,  50, 0, 0,   50, 0, 1, 7, 0);
        cyc(0, 1, 0, 0,  20, 0,   0, 0, 0,   20, 0, 1, 7, 0);
        cyc(0, 1, 0, 0,  20, 0,   0, 0, 0,   19, 0, 1, 7, 0);
        // mod_val 0: every step is a boundary
        cyc(0, 1, 1, 0,   0, 0,   0, 0, 0,    0, 1, 1, 7, 0);
        cyc(0, 1, 0, 0,   0, 0,   0, 0, 0,    0, 1, 1, 7, 0);
        cyc(0, 1, 1, 1,   0, 0,   0, 0, 0,    0, 1, 1, 7, 0);
        // capture during a step sees the pre-edge count
        cyc(0, 1, 1, 0,  20, 0,   0, 0, 0,    1, 0, 1, 7, 0);
        cyc(0, 1, 1, 0,  20, 0,   0, 1, 0,    2, 0, 1, 1, 1);
        // full range, mod_val all-ones
        cyc(0, 0, 1, 0, 255, 1, 254, 0, 0,  254, 0, 1, 1, 0);
        cyc(0, 1, 1, 0, 255, 0,   0, 0, 0,  255, 0, 1, 1, 0);
        cyc(0, 1, 1, 0, 255, 0,   0, 0, 0,    0, 1, 1, 1, 0);
        cyc(0, 1, 1, 0, 255, 0,   0, 0, 0,    1, 0, 1, 1, 0);
        // reset mid-count overrides capture and step
        cyc(1, 1, 1, 0, 255, 0,   0, 1, 0,    0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 255, 0,   0, 0, 0,    0, 0, 0, 0, 0);
        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            @(posedge clk_in);
            budget++;
        end
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
